wm_plant_responder: RTL and testbench
=====================================

// Module: wm_plant_responder
// PURPOSE
//  Sensor/plant side of the washer control interface: consumes actuator commands (fill_on, motor_on,
//  drain_on, door_lock) and returns tub sensors and timers (fill, detergent, timeout, drained, spin_timeout).
//  Closes the loop around the washing-machine controller FSM in system sims and FPGA demo.
//  Tracks a tub water level plus an internal phase FSM. All outputs are decoded from registered state.
// PARAMETERS
//  LEVEL_W     4   width of water-level counter
//  LEVEL_MAX   15  level at which tub reads full; must be <= 2**LEVEL_W-1
//  DOSE_CYCLES 3   cycles from DOSE entry to detergent pulse; >=1
//  WASH_CYCLES 20  motor_on cycles counted in WASH before timeout pulse; >=1
//  SPIN_CYCLES 10  drain_on cycles counted in SPIN before spin_timeout pulse; >=1
//  CNT_W       8   phase timer width; must hold max(DOSE,WASH,SPIN)_CYCLES
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        synchronous, active-high reset
//  door_lock    in   1        door locked command
//  fill_on      in   1        inlet valve command
//  motor_on     in   1        drum motor command
//  drain_on     in   1        drain pump / spin command
//  fill         out  1        level: tub full (level==LEVEL_MAX)
//  detergent    out  1        1-cycle pulse: dose dispensed
//  timeout      out  1        1-cycle pulse: wash time elapsed
//  drained      out  1        level: tub empty (level==0) while phase is DRAIN
//  spin_timeout out  1        1-cycle pulse: spin time elapsed
//  level        out  LEVEL_W  current water level
//  fault        out  1        sticky fault flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sync, priority over everything): phase=IDLE, level=0, timer=0, dosed=0, all outputs 0.
//  Phases: IDLE, FILL, DOSE, WASH, DRAIN, SPIN. timer clears on every phase change.
//  door_lock==0 in any phase: next phase IDLE, timer=0. level and dosed are held. No pulses are issued.
//  IDLE: fill_on -> FILL, and level increments on the same edge.
//  FILL: while fill_on, level+1 per cycle, saturating at LEVEL_MAX.
//   On !fill_on with level==LEVEL_MAX: -> DOSE if dosed==0, else -> WASH.
//   On !fill_on with level<LEVEL_MAX: stay in FILL and hold level.
//  DOSE: timer counts each cycle. When timer==DOSE_CYCLES-1: detergent=1 for that cycle only, dosed<=1, -> WASH.
//  WASH: timer increments only while motor_on. Cycle with motor_on && timer==WASH_CYCLES-1: timeout=1 (one cycle), -> DRAIN.
//  DRAIN: level-1 per cycle down to 0 (gravity valve, no command needed); drained = (level==0).
//   At level==0: fill_on -> FILL (rinse fill, level increments same edge); drain_on -> SPIN.
//   fill_on has priority if both are high.
//  SPIN: timer increments while drain_on. Cycle with drain_on && timer==SPIN_CYCLES-1: spin_timeout=1, dosed<=0, -> IDLE.
//  Commands not listed for the current phase are ignored.
//  Pulses are exactly one cycle and never overlap. fill/drained are levels.
//  Latency: command sampled at edge N is reflected in outputs after edge N.
// CONFIGURATION
//  WM_PLANT_FAULT_EN defined: fault is set (sticky until reset) by any of these cycles:
//   (fill_on && drain_on); (!door_lock && level!=0); (motor_on && level!=LEVEL_MAX);
//   (fill_on && level==LEVEL_MAX). Phase behaviour is unchanged.
//  WM_PLANT_FAULT_EN undefined: fault tied 0, no checker logic.
// TESTING
//  T1 full wash: lock=1, fill_on 15 cyc -> fill=1, level=15; fill_on=0 -> detergent pulse 3 cyc later;
//     motor_on 20 cyc -> timeout pulse on 20th; level falls to 0 in 15 cyc, drained=1.
//  T2 rinse/spin: from drained, fill_on -> FILL then WASH with no detergent pulse (dosed=1);
//     after timeout/drain, drain_on 10 cyc -> spin_timeout once, phase IDLE, dosed=0.
//  T3 door open mid-WASH (timer=7): door_lock=0 -> IDLE, level holds 15, no timeout;
//     with FAULT_EN, fault=1 next cycle.
//  T4 reset asserted mid-FILL (level=6) -> next cycle level=0, phase IDLE, all outputs 0; fault cleared.
//  T5 fill_on&&drain_on at DRAIN level 0 -> FILL taken; FAULT_EN: fault=1; FAULT_EN undefined: fault stays 0.
//  T6 motor_on toggled 1/0 in WASH -> timeout only after 20 motor_on cycles total (40 clk).

Source files
------------

// File: rtl/wm_plant_responder.sv
// rtl/wm_plant_responder.sv - washer plant model answering controller actuator commands with tub sensors
//
// Purpose: sensor/plant side of the washer control loop. Tracks tub water
// level and a phase FSM (IDLE, FILL, DOSE, WASH, DRAIN, SPIN) and returns
// level sensors plus one-cycle timer pulses to the controller.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   door_lock    in   door locked command; low forces IDLE
//   fill_on      in   inlet valve command
//   motor_on     in   drum motor command (advances wash timer)
//   drain_on     in   drain pump / spin command (advances spin timer)
//   fill         out  tub full (level == LEVEL_MAX)
//   detergent    out  one-cycle pulse, dose dispensed
//   timeout      out  one-cycle pulse, wash time elapsed
//   drained      out  tub empty while phase is DRAIN
//   spin_timeout out  one-cycle pulse, spin time elapsed
//   level        out  current water level
//   fault        out  sticky misuse flag
//
// Build option: define WM_PLANT_FAULT_EN to include the command misuse
// checker driving fault; otherwise fault is tied low.

module wm_plant_responder #(
    parameter int LEVEL_W     = 4,
    parameter int LEVEL_MAX   = 15,
    parameter int DOSE_CYCLES = 3,
    parameter int WASH_CYCLES = 20,
    parameter int SPIN_CYCLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_lock,
    input  logic               fill_on,
    input  logic               motor_on,
    input  logic               drain_on,
    output logic               fill,
    output logic               detergent,
    output logic               timeout,
    output logic               drained,
    output logic               spin_timeout,
    output logic [LEVEL_W-1:0] level,
    output logic               fault
);

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FILL,
        PH_DOSE,
        PH_WASH,
        PH_DRAIN,
        PH_SPIN
    } phase_t;

    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
    localparam logic [CNT_W-1:0]   DOSE_LAST = CNT_W'(DOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WASH_LAST = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);

    phase_t             phase;
    logic [CNT_W-1:0]   timer;
    logic               dosed;
    logic [LEVEL_W-1:0] level_inc;

    // Saturating increment; IDLE can be re-entered with a full tub after a door opening.
    assign level_inc = (level == LVL_MAX) ? level : level + LEVEL_W'(1);

    assign fill    = (level == LVL_MAX);
    assign drained = (phase == PH_DRAIN) && (level == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= PH_IDLE;
            timer        <= '0;
            dosed        <= 1'b0;
            level        <= '0;
            detergent    <= 1'b0;
            timeout      <= 1'b0;
            spin_timeout <= 1'b0;
        end else begin
            detergent    <= 1'b0;
            timeout      <= 1'b0;
            spin_timeout <= 1'b0;
            if (!door_lock) begin
                // Open door aborts the cycle; water and dose history survive.
                phase <= PH_IDLE;
                timer <= '0;
            end else begin
                case (phase)
                    PH_IDLE: begin
                        if (fill_on) begin
                            phase <= PH_FILL;
                            timer <= '0;
                            level <= level_inc;
                        end
                    end
                    PH_FILL: begin
                        if (fill_on) begin
                            level <= level_inc;
                        end else if (level == LVL_MAX) begin
                            phase <= dosed ? PH_WASH : PH_DOSE;
                            timer <= '0;
                        end
                    end
                    PH_DOSE: begin
                        if (timer == DOSE_LAST) begin
                            detergent <= 1'b1;
                            dosed     <= 1'b1;
                            phase     <= PH_WASH;
                            timer     <= '0;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    PH_WASH: begin
                        if (motor_on) begin
                            if (timer == WASH_LAST) begin
                                timeout <= 1'b1;
                                phase   <= PH_DRAIN;
                                timer   <= '0;
                            end else begin
                                timer <= timer + CNT_W'(1);
                            end
                        end
                    end
                    PH_DRAIN: begin
                        // Gravity drain runs first; commands only matter once empty.
                        if (level != '0) begin
                            level <= level - LEVEL_W'(1);
                        end else if (fill_on) begin
                            phase <= PH_FILL;
                            timer <= '0;
                            level <= level_inc;
                        end else if (drain_on) begin
                            phase <= PH_SPIN;
                            timer <= '0;
                        end
                    end
                    PH_SPIN: begin
                        if (drain_on) begin
                            if (timer == SPIN_LAST) begin
                                spin_timeout <= 1'b1;
                                dosed        <= 1'b0;
                                phase        <= PH_IDLE;
                                timer        <= '0;
                            end else begin
                                timer <= timer + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        phase <= PH_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

`ifdef WM_PLANT_FAULT_EN
    logic fault_hit;

    assign fault_hit = (fill_on && drain_on)
                     || (!door_lock && (level != '0))
                     || (motor_on && (level != LVL_MAX))
                     || (fill_on && (level == LVL_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (fault_hit) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_wm_plant_responder.sv
// tb/tb_wm_plant_responder.sv - randomized and directed self-checking bench for wm_plant_responder

module tb_wm_plant_responder;

    localparam int LMAX = 15;
    localparam int DOSE = 3;
    localparam int WASH = 20;
    localparam int SPIN = 10;

    logic       clk = 1'b0;
    logic       reset, door_lock, fill_on, motor_on, drain_on;
    logic       fill, detergent, timeout, drained, spin_timeout, fault;
    logic [3:0] level;

    int n_cmp = 0;
    int n_err = 0;

    wm_plant_responder dut (
        .clk          (clk),
        .reset        (reset),
        .door_lock    (door_lock),
        .fill_on      (fill_on),
        .motor_on     (motor_on),
        .drain_on     (drain_on),
        .fill         (fill),
        .detergent    (detergent),
        .timeout      (timeout),
        .drained      (drained),
        .spin_timeout (spin_timeout),
        .level        (level),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Reference model: phase as a name, counters as plain integers.
    string m_ph    = "IDLE";
    int    m_lvl   = 0;
    int    m_tmr   = 0;
    int    m_dosed = 0;
    int    m_fault = 0;
    int    m_det   = 0;
    int    m_to    = 0;
    int    m_st    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic goto_phase(input string p);
        if (p != m_ph) m_tmr = 0;
        m_ph = p;
    endtask

    task automatic model_step(input logic r, input logic lk, input logic f, input logic m, input logic d);
        m_det = 0; m_to = 0; m_st = 0;
        if (r) begin
            m_ph = "IDLE"; m_lvl = 0; m_tmr = 0; m_dosed = 0; m_fault = 0;
            return;
        end
        if ((f && d) || (!lk && m_lvl != 0) || (m && m_lvl != LMAX) || (f && m_lvl == LMAX))
            m_fault = 1;
        if (!lk) begin
            goto_phase("IDLE");
            m_tmr = 0;
            return;
        end
        if (m_ph == "IDLE") begin
            if (f) begin goto_phase("FILL"); m_lvl = (m_lvl < LMAX) ? m_lvl + 1 : LMAX; end
        end else if (m_ph == "FILL") begin
            if (f) m_lvl = (m_lvl < LMAX) ? m_lvl + 1 : LMAX;
            else if (m_lvl == LMAX) goto_phase(m_dosed ? "WASH" : "DOSE");
        end else if (m_ph == "DOSE") begin
            m_tmr++;
            if (m_tmr == DOSE) begin m_det = 1; m_dosed = 1; goto_phase("WASH"); end
        end else if (m_ph == "WASH") begin
            if (m) begin
                m_tmr++;
                if (m_tmr == WASH) begin m_to = 1; goto_phase("DRAIN"); end
            end
        end else if (m_ph == "DRAIN") begin
            if (m_lvl > 0) m_lvl--;
            else if (f) begin goto_phase("FILL"); m_lvl = 1; end
            else if (d) goto_phase("SPIN");
        end else if (m_ph == "SPIN") begin
            if (d) begin
                m_tmr++;
                if (m_tmr == SPIN) begin m_st = 1; m_dosed = 0; goto_phase("IDLE"); end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic lk, input logic f, input logic m, input logic d);
        reset = r; door_lock = lk; fill_on = f; motor_on = m; drain_on = d;
        @(posedge clk);
        model_step(r, lk, f, m, d);
        #1;
        check("level",        level,        m_lvl);
        check("fill",         fill,         (m_lvl == LMAX));
        check("drained",      drained,      (m_ph == "DRAIN" && m_lvl == 0));
        check("detergent",    detergent,    m_det);
        check("timeout",      timeout,      m_to);
        check("spin_timeout", spin_timeout, m_st);
`ifdef WM_PLANT_FAULT_EN
        check("fault",        fault,        m_fault);
`else
        check("fault",        fault,        0);
`endif
    endtask

    task automatic fill_full();
        repeat (LMAX) cycle(0, 1, 1, 0, 0);
    endtask

    initial begin
        int n;
        int dets;
        logic lk, f, m, d, r;

        reset = 1; door_lock = 0; fill_on = 0; motor_on = 0; drain_on = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("rst_level", level, 0);

        // T1 full wash
        fill_full();
        check("t1_level_full", level, LMAX);
        check("t1_fill", fill, 1);
        n = 0;
        while (n < 20) begin cycle(0, 1, 0, 0, 0); n++; if (detergent) break; end
        check("t1_dose_latency", n, DOSE + 1);
        n = 0;
        while (n < 60) begin cycle(0, 1, 0, 1, 0); n++; if (timeout) break; end
        check("t1_wash_cycles", n, WASH);
        n = 0;
        while (n < 40) begin cycle(0, 1, 0, 0, 0); n++; if (drained) break; end
        check("t1_drain_cycles", n, LMAX);

        // T2 rinse without a second dose, then spin
        dets = 0;
        fill_full();
        check("t2_level_full", level, LMAX);
        n = 0;
        while (n < 60) begin
            cycle(0, 1, 0, (n > 0), 0);
            if (detergent) dets++;
            n++;
            if (timeout) break;
        end
        check("t2_no_dose", dets, 0);
        check("t2_wash_cycles", n, WASH + 1);
        repeat (LMAX) cycle(0, 1, 0, 0, 0);
        check("t2_drained", drained, 1);
        n = 0;
        while (n < 40) begin cycle(0, 1, 0, 0, 1); n++; if (spin_timeout) break; end
        check("t2_spin_cycles", n, SPIN + 1);
        cycle(0, 1, 0, 0, 1);
        check("t2_no_second_spin", spin_timeout, 0);

        // T3 door open mid-wash at timer 7
        cycle(1, 1, 0, 0, 0);
        fill_full();
        repeat (DOSE + 1) cycle(0, 1, 0, 0, 0);
        repeat (7) cycle(0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("t3_level_held", level, LMAX);
        check("t3_no_timeout", timeout, 0);
`ifdef WM_PLANT_FAULT_EN
        check("t3_fault", fault, 1);
`endif
        repeat (30) cycle(0, 1, 0, 1, 0);

        // T4 reset mid-fill
        cycle(1, 1, 0, 0, 0);
        repeat (6) cycle(0, 1, 1, 0, 0);
        check("t4_level6", level, 6);
        cycle(1, 1, 1, 0, 0);
        check("t4_level0", level, 0);
        check("t4_fault_clr", fault, 0);

        // T5 fill_on and drain_on together at empty drain
        fill_full();
        repeat (DOSE + 1) cycle(0, 1, 0, 0, 0);
        repeat (WASH) cycle(0, 1, 0, 1, 0);
        repeat (LMAX) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 1);
        check("t5_fill_taken", level, 1);
`ifdef WM_PLANT_FAULT_EN
        check("t5_fault", fault, 1);
`else
        check("t5_fault", fault, 0);
`endif

        // T6 toggling motor in wash
        repeat (LMAX - 1) cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        n = 0;
        while (n < 100) begin cycle(0, 1, 0, n[0], 0); n++; if (timeout) break; end
        check("t6_toggle_cycles", n, 2 * WASH);

        // Randomized commands, biased by the model phase to make progress
        cycle(1, 1, 0, 0, 0);
        repeat (3000) begin
            r  = ($urandom_range(0, 299) == 0);
            lk = ($urandom_range(0, 59) != 0);
            f  = ($urandom_range(0, 19) == 0);
            m  = ($urandom_range(0, 19) == 0);
            d  = ($urandom_range(0, 19) == 0);
            if (m_ph == "IDLE")  f = ($urandom_range(0, 9) < 5);
            if (m_ph == "FILL")  f = ($urandom_range(0, 9) < 8);
            if (m_ph == "WASH")  m = ($urandom_range(0, 9) < 7);
            if (m_ph == "DRAIN") begin f = ($urandom_range(0, 9) < 2); d = ($urandom_range(0, 9) < 5); end
            if (m_ph == "SPIN")  d = ($urandom_range(0, 9) < 7);
            cycle(r, lk, f, m, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
